// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//
// Two-port round-robin scheduler in front of a single-access SDRAM
// controller that has no busy/acknowledge output. The arbiter keeps a
// cycle-exact shadow of the controller's init, access and auto-refresh
// timing, and only raises RD_REQ/WR_REQ on a cycle where the controller is
// known to be idle with no refresh due.
//
// Ports:
//   CLK, nRESET            clock shared with the controller; async active-low
//                          reset (same net as the controller's reset)
//   A_REQ/A_WE/A_ADDR/     port A request level, write enable, word address,
//   A_WDATA                write data (held stable while A_REQ is high)
//   A_ACK, A_RDATA         one-cycle completion pulse; read data valid with ACK
//   B_*                    identical set for port B
//   RD_REQ, WR_REQ         one-cycle access request to the controller
//   RD_ADDR, WR_ADDR       latched access address (always equal)
//   WR_DATA                latched write data
//   RD_DATA                read data from the controller
//   INIT_DONE              high once the init shadow has completed
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int INIT_CYCLES      = 15007,
    parameter int REFRESH_INTERVAL = 8,
    parameter int BUSY_CYCLES      = 6
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        A_REQ,
    input  logic        A_WE,
    input  logic [21:0] A_ADDR,
    input  logic [15:0] A_WDATA,
    output logic        A_ACK,
    output logic [15:0] A_RDATA,
    input  logic        B_REQ,
    input  logic        B_WE,
    input  logic [21:0] B_ADDR,
    input  logic [15:0] B_WDATA,
    output logic        B_ACK,
    output logic [15:0] B_RDATA,
    output logic        RD_REQ,
    output logic        WR_REQ,
    output logic [21:0] RD_ADDR,
    output logic [21:0] WR_ADDR,
    output logic [15:0] WR_DATA,
    input  logic [15:0] RD_DATA,
    output logic        INIT_DONE
);

    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int BW = $clog2(BUSY_CYCLES + 1);

    localparam logic [IW-1:0] INIT_LOAD     = IW'(INIT_CYCLES);
    localparam logic [IW-1:0] INIT_LAST     = IW'(1);
    localparam logic [BW-1:0] BUSY_LOAD     = BW'(BUSY_CYCLES);
    localparam logic [BW-1:0] BUSY_CAP      = BW'(2);
    localparam logic [BW-1:0] BUSY_LAST     = BW'(1);
    localparam logic [BW-1:0] BUSY_STEP     = BW'(1);
    localparam logic [3:0]    REF_SAT       = 4'(REFRESH_INTERVAL);
    // Granting at REF <= SAT-2 keeps REF below saturation in the ISSUE cycle,
    // so the controller can never see a request and a due refresh together.
    localparam logic [3:0]    REF_GRANT_MAX = 4'(REFRESH_INTERVAL - 2);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_REFRESH = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_BUSY    = 3'd4
    } state_t;

    state_t        state_r;
    logic [IW-1:0] init_cnt_r;
    logic [BW-1:0] busy_cnt_r;
    logic [3:0]    ref_r;
    logic          last_b_r;
    logic          gnt_b_r;
    logic          we_r;
    logic [21:0]   addr_r;
    logic [15:0]   wdata_r;
    logic          rd_req_r;
    logic          wr_req_r;
    logic          a_ack_r;
    logic          b_ack_r;
    logic [15:0]   a_rdata_r;
    logic [15:0]   b_rdata_r;
    logic          init_done_r;

    logic          grant_b_s;
    logic          can_grant_s;
    logic          sel_we_s;
    logic [21:0]   sel_addr_s;
    logic [15:0]   sel_wdata_s;

    // Round-robin pick: a lone request wins, a tie goes to the port not granted last.
    always_comb begin
        grant_b_s   = 1'b0;
        can_grant_s = 1'b0;
        if (B_REQ && (!A_REQ || !last_b_r)) begin
            grant_b_s = 1'b1;
        end else begin
            grant_b_s = 1'b0;
        end
        if ((ref_r <= REF_GRANT_MAX) && (A_REQ || B_REQ)) begin
            can_grant_s = 1'b1;
        end else begin
            can_grant_s = 1'b0;
        end
    end

    // Mux the winning port's request fields toward the issue registers.
    always_comb begin
        sel_we_s    = A_WE;
        sel_addr_s  = A_ADDR;
        sel_wdata_s = A_WDATA;
        if (grant_b_s) begin
            sel_we_s    = B_WE;
            sel_addr_s  = B_ADDR;
            sel_wdata_s = B_WDATA;
        end else begin
            sel_we_s    = A_WE;
            sel_addr_s  = A_ADDR;
            sel_wdata_s = A_WDATA;
        end
    end

    // Shadow of the controller's refresh timer: saturates, cleared by the refresh.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            ref_r <= 4'd0;
        end else if (state_r == ST_REFRESH) begin
            ref_r <= 4'd0;
        end else if (ref_r != REF_SAT) begin
            ref_r <= ref_r + 4'd1;
        end else begin
            ref_r <= ref_r;
        end
    end

    // Main scheduler FSM with all controller- and port-facing outputs registered.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= INIT_LOAD;
            busy_cnt_r  <= {BW{1'b0}};
            last_b_r    <= 1'b1;
            gnt_b_r     <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 22'd0;
            wdata_r     <= 16'd0;
            rd_req_r    <= 1'b0;
            wr_req_r    <= 1'b0;
            a_ack_r     <= 1'b0;
            b_ack_r     <= 1'b0;
            a_rdata_r   <= 16'd0;
            b_rdata_r   <= 16'd0;
            init_done_r <= 1'b0;
        end else begin
            a_ack_r <= 1'b0;
            b_ack_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r == INIT_LAST) begin
                        state_r     <= ST_IDLE;
                        init_done_r <= 1'b1;
                    end else begin
                        init_cnt_r  <= init_cnt_r - IW'(1);
                    end
                end
                ST_IDLE: begin
                    if (ref_r == REF_SAT) begin
                        // The controller itself starts a refresh in this cycle.
                        state_r <= ST_REFRESH;
                    end else if (can_grant_s) begin
                        state_r  <= ST_ISSUE;
                        gnt_b_r  <= grant_b_s;
                        last_b_r <= grant_b_s;
                        we_r     <= sel_we_s;
                        addr_r   <= sel_addr_s;
                        wdata_r  <= sel_wdata_s;
                        rd_req_r <= ~sel_we_s;
                        wr_req_r <= sel_we_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REFRESH: begin
                    state_r <= ST_IDLE;
                end
                ST_ISSUE: begin
                    rd_req_r   <= 1'b0;
                    wr_req_r   <= 1'b0;
                    busy_cnt_r <= BUSY_LOAD;
                    state_r    <= ST_BUSY;
                end
                ST_BUSY: begin
                    busy_cnt_r <= busy_cnt_r - BUSY_STEP;
                    // Second-to-last busy cycle: controller read data is valid now,
                    // and registering ACK here puts its pulse in the last cycle.
                    if (busy_cnt_r == BUSY_CAP) begin
                        if (gnt_b_r) begin
                            b_ack_r <= 1'b1;
                            if (!we_r) begin
                                b_rdata_r <= RD_DATA;
                            end
                        end else begin
                            a_ack_r <= 1'b1;
                            if (!we_r) begin
                                a_rdata_r <= RD_DATA;
                            end
                        end
                    end
                    if (busy_cnt_r == BUSY_LAST) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    assign A_ACK     = a_ack_r;
    assign B_ACK     = b_ack_r;
    assign A_RDATA   = a_rdata_r;
    assign B_RDATA   = b_rdata_r;
    assign RD_REQ    = rd_req_r;
    assign WR_REQ    = wr_req_r;
    // The controller takes the row from WR_ADDR while idle, so both carry the latch.
    assign RD_ADDR   = addr_r;
    assign WR_ADDR   = addr_r;
    assign WR_DATA   = wdata_r;
    assign INIT_DONE = init_done_r;

endmodule
